// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle result pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity error pulse.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_rx_valid,
   output logic [7:0] uart_rx_data,
   output logic       uart_rx_frame_err,
   output logic       uart_rx_parity_err,
   output logic       uart_rx_busy
);

   localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_data;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_prev;
   logic        r_valid;
   logic        r_frame_err;
`ifdef UART_RX_PARITY_EN
   logic        r_parity_bit;
   logic        r_parity_err;
   logic        w_parity_bad;
`endif

   logic w_fall;
   logic w_bit_end;

   assign w_fall    = r_prev & ~r_sync2;
   assign w_bit_end = (r_cnt == FULL_BIT);
`ifdef UART_RX_PARITY_EN
   assign w_parity_bad = ^{r_shift, r_parity_bit};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_prev      <= 1'b1;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_bit <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_sync1     <= uart_rxd;
         r_sync2     <= r_sync1;
         r_prev      <= r_sync2;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_fall)
                  r_state <= S_START;
            end
            // Re-check the start bit at its centre to reject glitches.
            S_START: begin
               if (r_cnt == HALF_BIT) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= r_sync2 ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_shift <= {r_sync2, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_cnt        <= '0;
                  r_parity_bit <= r_sync2;
                  r_state      <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
`endif
            // Leave at mid-stop so a back-to-back start edge is still caught.
            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (!r_sync2) begin
                     r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (w_parity_bad) begin
                     r_parity_err <= 1'b1;
`endif
                  end else begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign uart_rx_valid     = r_valid;
   assign uart_rx_data      = r_data;
   assign uart_rx_frame_err = r_frame_err;
   assign uart_rx_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign uart_rx_parity_err = r_parity_err;
`else
   assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: normal, false-start, framing-error,
// back-to-back, mid-frame reset and (with UART_RX_PARITY_EN) parity frames.
module tb_uart_rx;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int LAT_MIN = 2 + (19 * C) / 2 + (FRAME_BITS - 10) * C;
   localparam int LAT_MAX = LAT_MIN + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rxd;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic       uart_rx_frame_err;
   logic       uart_rx_parity_err;
   logic       uart_rx_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   int overlap_cnt = 0;
   int last_vcyc = 0;
   int prev_vcyc = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] b55 = 8'h55;
`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk               (clk),
      .rst               (rst),
      .uart_rxd          (uart_rxd),
      .uart_rx_valid     (uart_rx_valid),
      .uart_rx_data      (uart_rx_data),
      .uart_rx_frame_err (uart_rx_frame_err),
      .uart_rx_parity_err(uart_rx_parity_err),
      .uart_rx_busy      (uart_rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (uart_rx_valid) begin
         valid_cnt <= valid_cnt + 1;
         prev_vcyc <= last_vcyc;
         last_vcyc <= cyc;
         prev_data <= last_data;
         last_data <= uart_rx_data;
      end
      if (uart_rx_frame_err) ferr_cnt <= ferr_cnt + 1;
      if (uart_rx_parity_err) perr_cnt <= perr_cnt + 1;
      if (int'(uart_rx_valid) + int'(uart_rx_frame_err) + int'(uart_rx_parity_err) > 1)
         overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
      $display("check %-18s got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      uart_rxd = v;
      wait_cycles(C);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_b);
      fall_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
`endif
      drive_bit(stop_b);
      $display("sent frame %02h stop=%0b", b, stop_b);
   endtask

   initial begin
      rst = 1'b1;
      uart_rxd = 1'b1;
      wait_cycles(3);
      check("rst_valid", {31'd0, uart_rx_valid}, 32'd0);
      check("rst_data", {24'd0, uart_rx_data}, 32'h00);
      check("rst_frame_err", {31'd0, uart_rx_frame_err}, 32'd0);
      check("rst_parity_err", {31'd0, uart_rx_parity_err}, 32'd0);
      check("rst_busy", {31'd0, uart_rx_busy}, 32'd0);
      rst = 1'b0;
      wait_cycles(5);

      // Clean 0xA5 frame
      send_frame(8'hA5, 1'b1);
      wait_cycles(4);
      check("a5_valid_cnt", valid_cnt, 32'd1);
      check("a5_data", {24'd0, uart_rx_data}, 32'hA5);
      check("a5_pulse_data", {24'd0, last_data}, 32'hA5);
      check("a5_busy_after", {31'd0, uart_rx_busy}, 32'd0);
      check("a5_latency_ok", {31'd0, (last_vcyc - fall_cyc >= LAT_MIN) &&
                                     (last_vcyc - fall_cyc <= LAT_MAX)}, 32'd1);
      wait_cycles(10);

      // False start: 4 low cycles
      uart_rxd = 1'b0;
      wait_cycles(4);
      uart_rxd = 1'b1;
      wait_cycles(1);
      check("fs_busy_during", {31'd0, uart_rx_busy}, 32'd1);
      wait_cycles(30);
      check("fs_busy_after", {31'd0, uart_rx_busy}, 32'd0);
      check("fs_valid_cnt", valid_cnt, 32'd1);
      check("fs_ferr_cnt", ferr_cnt, 32'd0);

      // Framing error, line then held low
      send_frame(8'h3C, 1'b0);
      uart_rxd = 1'b0;
      wait_cycles(64);
      check("fe_ferr_cnt", ferr_cnt, 32'd1);
      check("fe_valid_cnt", valid_cnt, 32'd1);
      check("fe_data_kept", {24'd0, uart_rx_data}, 32'hA5);
      check("fe_no_restart", {31'd0, uart_rx_busy}, 32'd0);
      uart_rxd = 1'b1;
      wait_cycles(20);
      check("fe_rise_idle", {31'd0, uart_rx_busy}, 32'd0);

      // Back-to-back 0x01, 0xFF
      send_frame(8'h01, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_cycles(10);
      check("b2b_valid_cnt", valid_cnt, 32'd3);
      check("b2b_first", {24'd0, prev_data}, 32'h01);
      check("b2b_second", {24'd0, last_data}, 32'hFF);
      check("b2b_spacing", last_vcyc - prev_vcyc, FRAME_BITS * C);
      check("b2b_ferr_cnt", ferr_cnt, 32'd1);

      // Reset during data bit 4 of 0x55
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b55[i]);
      uart_rxd = b55[4];
      wait_cycles(C / 2);
      rst = 1'b1;
      #1;
      check("mr_busy_in_rst", {31'd0, uart_rx_busy}, 32'd0);
      wait_cycles(2);
      rst = 1'b0;
      uart_rxd = 1'b1;
      wait_cycles(200);
      check("mr_data_cleared", {24'd0, uart_rx_data}, 32'h00);
      check("mr_valid_cnt", valid_cnt, 32'd3);
      check("mr_ferr_cnt", ferr_cnt, 32'd1);
      send_frame(8'h81, 1'b1);
      wait_cycles(10);
      check("mr_81_valid_cnt", valid_cnt, 32'd4);
      check("mr_81_data", {24'd0, uart_rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
      par_flip = 1'b1;
      send_frame(8'h03, 1'b1);
      wait_cycles(10);
      check("par_bad_perr", perr_cnt, 32'd1);
      check("par_bad_valid", valid_cnt, 32'd4);
      check("par_bad_data", {24'd0, uart_rx_data}, 32'h81);
      par_flip = 1'b0;
      send_frame(8'h03, 1'b1);
      wait_cycles(10);
      check("par_ok_valid", valid_cnt, 32'd5);
      check("par_ok_data", {24'd0, uart_rx_data}, 32'h03);
      check("par_ok_perr", perr_cnt, 32'd1);
`else
      check("perr_never", perr_cnt, 32'd0);
`endif
      check("pulse_overlap", overlap_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
